hdr_assembler: RTL and testbench
================================

# hdr_assembler

Parametrised header assembler for the event path: buffers the TURF header stream and NUM_TIO TURFIO header streams in per-source FIFOs, then emits one contiguous AXI4-Stream header record per event. The record is the TURF header, then each TURFIO header in channel order. Masked TURFIOs get synthetic beats, so downstream always sees a fixed-length record. It sits between the TURFIO header deserialisers and the memory-side event writer, in aclk domain only.

## Interface
- NUM_TIO, 4, number of TURFIO header channels (1–8)
- DATA_WIDTH, 64, beat width in bits (multiple of 32)
- THDR_BEATS, 8, TURF header beats per event
- TIO_BEATS, 4, TURFIO header beats per event per channel
- FIFO_DEPTH, 16, per-source FIFO depth in beats (power of 2, ≥ 2·max(THDR_BEATS,TIO_BEATS))
- FAKE_MAGIC, 16'hFA6E, upper 16 bits of synthetic beats
- aclk  in  1  sole clock
- areset  in  1  asynchronous, active-high reset
- tio_mask_i  in  NUM_TIO  per-channel mask; 1 = ignore stream, emit synthetic beats
- s_thdr_tdata / s_thdr_tvalid / s_thdr_tready / s_thdr_tlast  in/in/out/in  DATA_WIDTH/1/1/1  TURF header stream
- s_hdr_tdata / s_hdr_tvalid / s_hdr_tready / s_hdr_tlast  in/in/out/in  NUM_TIO·DATA_WIDTH / NUM_TIO / NUM_TIO / NUM_TIO  packed TURFIO header streams, channel i at slice i
- m_hdr_tdata / m_hdr_tvalid / m_hdr_tready / m_hdr_tlast  out/out/in/out  DATA_WIDTH/1/1/1  assembled record
- event_count_o  out  16  records fully emitted, wraps at 16'hFFFF→0
- err_o  out  NUM_TIO  sticky per-channel length error (cleared only by areset)

## Operation
- Each source has its own FIFO storing {tlast, tdata}. s_*_tready = !full.
- Masked channel i: s_hdr_tready[i]=1. Beats are discarded and never written.
- Output FSM states:
  - IDLE: go to THDR when the thdr FIFO is non-empty; latch tio_mask_i into mask_q at that transition.
  - THDR: pass THDR_BEATS beats from the thdr FIFO.
  - TIO: channel index ch = 0..NUM_TIO-1, beat counter 0..TIO_BEATS-1.
  - Back to IDLE after the last beat of channel NUM_TIO-1.
- A tio_mask_i change mid-record takes effect at the next record only.
- TIO state, unmasked ch: stall (m_hdr_tvalid=0) while the FIFO is empty, then pop one beat per output transfer.
- TIO state, masked ch: emit {FAKE_MAGIC, ch[7:0], beat[7:0], zeros} with no stall.
- m_hdr_tlast=1 only on the final beat of channel NUM_TIO-1. Input tlast is never forwarded.
- The THDR length is counted; thdr tlast is ignored.
- event_count_o increments on the tlast transfer.

## Timing
- Reset values: all FIFOs empty, FSM=IDLE, m_hdr_tvalid=0, m_hdr_tlast=0, m_hdr_tdata=0, event_count_o=0, err_o=0, s_*_tready=1.
- The output is a registered stage with full throughput: one beat per cycle while m_hdr_tready=1 and data is available.
- Latency:
  - A beat written to an empty FIFO is readable the next cycle.
  - It appears on m_hdr_tvalid two cycles after its input handshake when the FSM is waiting on it.
- m_hdr_tdata/tlast hold stable while m_hdr_tvalid && !m_hdr_tready.
- Simultaneous write and read on a full FIFO: the read frees a slot next cycle. tready is not combinationally derived from the read.
- areset mid-record: the record is abandoned and partially buffered beats are flushed. The next record starts clean.

## Configuration
- HDR_ASSEMBLER_LENCHK_EN defined: unmasked channels use tlast.
  - tlast seen before beat TIO_BEATS-1: set err_o[ch] and pad the remaining beats with zeros, without popping.
  - No tlast by beat TIO_BEATS-1: set err_o[ch], emit TIO_BEATS beats, then discard FIFO beats up to and including tlast before advancing.
- Undefined: exactly TIO_BEATS beats are popped blindly, stored tlast is ignored, and err_o is tied to 0.

## Structure
- hdr_assembler_pkg:
  - FSM state enum (IDLE, THDR, TIO)
  - FAKE beat field offsets
  - event counter width constant
- Sub-module hdr_sync_fifo: single-clock, first-word-fall-through, parameters DEPTH and WIDTH, one instance per source (NUM_TIO+1 instances).

## Test plan
- All unmasked, NUM_TIO=4: 8 thdr beats plus 4 beats per channel, pre-filled; m_hdr_tready=1 → 24 consecutive beats in order, tlast on beat 23, event_count_o=1.
- tio_mask_i=4'b0100: channel 2 input driven with garbage → beats 16..19 are 0xFA6E_02_00.., 0xFA6E_02_01.., 0xFA6E_02_02.., 0xFA6E_02_03..; garbage never appears.
- Channel 3 data delayed 50 cycles after the others → output stalls after channel 2 with no bubble corruption, then resumes; m_hdr_tready toggling 50% gives identical data.
- Mask flipped to 4'b0001 during the THDR phase → current record unmasked, next record has channel 0 synthetic.
- LENCHK_EN: channel 1 sends tlast on beat 1 → err_o=4'b0010, beats 2–3 of channel 1 are zero, next record aligned. Without the macro: err_o stays 0.
- Fill the thdr FIFO to FIFO_DEPTH with m_hdr_tready=0 → s_thdr_tready=0. Then assert areset mid-record → all outputs at reset values and the next record correct.

Source files
------------

// File: rtl/hdr_assembler_pkg.sv
// Shared types and constants for the event header assembler: FSM states,
// synthetic-beat field layout and the event counter width.
package hdr_assembler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_THDR,
        ST_TIO
    } hdr_state_e;

    // Synthetic beat tag occupies the top 32 bits: {magic, channel, beat}.
    localparam int FAKE_TAG_W     = 32;
    localparam int FAKE_MAGIC_OFS = 16;
    localparam int FAKE_CH_OFS    = 8;
    localparam int FAKE_BEAT_OFS  = 0;

    localparam int EVENT_CNT_W = 16;

    function automatic logic [FAKE_TAG_W-1:0] fake_tag(
        input logic [15:0] magic,
        input logic [7:0]  ch,
        input logic [7:0]  beat
    );
        logic [FAKE_TAG_W-1:0] tag;
        tag = '0;
        tag[FAKE_MAGIC_OFS +: 16] = magic;
        tag[FAKE_CH_OFS    +: 8]  = ch;
        tag[FAKE_BEAT_OFS  +: 8]  = beat;
        return tag;
    endfunction

endpackage

// File: rtl/hdr_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; the head entry is visible on
// rd_data whenever empty is low, and full is derived only from registered state.
module hdr_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 65
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;

    // NOTE: the storage array has no reset; flushing is done by clearing the
    // pointers, and a reset on the array would only cost flops without changing behaviour.
    always_ff @(posedge aclk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hdr_assembler.sv
// Event header assembler: TURF header then each TURFIO header in channel order,
// masked channels replaced by synthetic beats. Option macro: HDR_ASSEMBLER_LENCHK_EN.
module hdr_assembler
    import hdr_assembler_pkg::*;
#(
    parameter int          NUM_TIO    = 4,
    parameter int          DATA_WIDTH = 64,
    parameter int          THDR_BEATS = 8,
    parameter int          TIO_BEATS  = 4,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] FAKE_MAGIC = 16'hFA6E
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [NUM_TIO-1:0]            tio_mask_i,
    input  logic [DATA_WIDTH-1:0]         s_thdr_tdata,
    input  logic                          s_thdr_tvalid,
    output logic                          s_thdr_tready,
    input  logic                          s_thdr_tlast,
    input  logic [NUM_TIO*DATA_WIDTH-1:0] s_hdr_tdata,
    input  logic [NUM_TIO-1:0]            s_hdr_tvalid,
    output logic [NUM_TIO-1:0]            s_hdr_tready,
    input  logic [NUM_TIO-1:0]            s_hdr_tlast,
    output logic [DATA_WIDTH-1:0]         m_hdr_tdata,
    output logic                          m_hdr_tvalid,
    input  logic                          m_hdr_tready,
    output logic                          m_hdr_tlast,
    output logic [EVENT_CNT_W-1:0]        event_count_o,
    output logic [NUM_TIO-1:0]            err_o
);

    localparam int CH_W     = (NUM_TIO > 1) ? $clog2(NUM_TIO) : 1;
    localparam int MAX_BEAT = (THDR_BEATS > TIO_BEATS) ? THDR_BEATS : TIO_BEATS;
    localparam int BEAT_W   = $clog2(MAX_BEAT) + 1;

    hdr_state_e          state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [NUM_TIO-1:0]  mask_q, mask_d;

    logic                thdr_wr, thdr_pop, thdr_full, thdr_empty;
    logic [DATA_WIDTH:0] thdr_q;
    logic [NUM_TIO-1:0]  tio_wr, tio_pop, tio_full, tio_empty, tio_last;
    logic [DATA_WIDTH:0] tio_q [NUM_TIO];
    logic [DATA_WIDTH-1:0] cur_data;

    logic                  load_en, emit, emit_last, beat_step, ch_done;
    logic [DATA_WIDTH-1:0] emit_data;
    logic                  last_ch, thdr_last_beat, tio_last_beat;
    logic                  unused_tlast;

    assign s_thdr_tready = !thdr_full;
    assign thdr_wr       = s_thdr_tvalid && !thdr_full;

    hdr_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_WIDTH + 1)) u_thdr_fifo (
        .aclk    (aclk),
        .areset  (areset),
        .wr_en   (thdr_wr),
        .wr_data ({s_thdr_tlast, s_thdr_tdata}),
        .rd_en   (thdr_pop),
        .rd_data (thdr_q),
        .full    (thdr_full),
        .empty   (thdr_empty)
    );

    // Masked channels always accept and drop their beats.
    for (genvar i = 0; i < NUM_TIO; i++) begin : g_tio
        assign s_hdr_tready[i] = tio_mask_i[i] || !tio_full[i];
        assign tio_wr[i]       = s_hdr_tvalid[i] && !tio_mask_i[i] && !tio_full[i];
        assign tio_last[i]     = tio_q[i][DATA_WIDTH];

        hdr_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_WIDTH + 1)) u_tio_fifo (
            .aclk    (aclk),
            .areset  (areset),
            .wr_en   (tio_wr[i]),
            .wr_data ({s_hdr_tlast[i], s_hdr_tdata[i*DATA_WIDTH +: DATA_WIDTH]}),
            .rd_en   (tio_pop[i]),
            .rd_data (tio_q[i]),
            .full    (tio_full[i]),
            .empty   (tio_empty[i])
        );
    end

    assign unused_tlast   = ^{thdr_q[DATA_WIDTH], tio_last};
    assign cur_data       = tio_q[ch_q][DATA_WIDTH-1:0];
    assign load_en        = !m_hdr_tvalid || m_hdr_tready;
    assign last_ch        = (ch_q == CH_W'(NUM_TIO - 1));
    assign thdr_last_beat = (beat_q == BEAT_W'(THDR_BEATS - 1));
    assign tio_last_beat  = (beat_q == BEAT_W'(TIO_BEATS - 1));

`ifdef HDR_ASSEMBLER_LENCHK_EN
    logic               pad_q, pad_d, drain_q, drain_d;
    logic [NUM_TIO-1:0] err_q, err_set;
    logic               cur_last;

    assign cur_last = tio_last[ch_q];
    assign err_o    = err_q;
`else
    assign err_o = '0;
`endif

    // NOTE: every combinational output gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        beat_d    = beat_q;
        mask_d    = mask_q;
        thdr_pop  = 1'b0;
        tio_pop   = '0;
        emit      = 1'b0;
        emit_data = '0;
        emit_last = 1'b0;
        beat_step = 1'b0;
        ch_done   = 1'b0;
`ifdef HDR_ASSEMBLER_LENCHK_EN
        pad_d     = pad_q;
        drain_d   = drain_q;
        err_set   = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!thdr_empty) begin
                    state_d = ST_THDR;
                    mask_d  = tio_mask_i;
                    beat_d  = '0;
                end
            end
            ST_THDR: begin
                if (load_en && !thdr_empty) begin
                    emit      = 1'b1;
                    emit_data = thdr_q[DATA_WIDTH-1:0];
                    thdr_pop  = 1'b1;
                    if (thdr_last_beat) begin
                        state_d = ST_TIO;
                        ch_d    = '0;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            ST_TIO: begin
                if (mask_q[ch_q]) begin
                    if (load_en) begin
                        emit      = 1'b1;
                        emit_data[DATA_WIDTH-1 -: FAKE_TAG_W] =
                            fake_tag(FAKE_MAGIC, 8'(ch_q), 8'(beat_q));
                        beat_step = 1'b1;
                    end
                end else begin
`ifdef HDR_ASSEMBLER_LENCHK_EN
                    // Drain discards leftovers up to the stored tlast; pad emits zeros.
                    if (drain_q) begin
                        if (!tio_empty[ch_q]) begin
                            tio_pop[ch_q] = 1'b1;
                            if (cur_last) begin
                                drain_d = 1'b0;
                                ch_done = 1'b1;
                            end
                        end
                    end else if (pad_q) begin
                        if (load_en) begin
                            emit      = 1'b1;
                            beat_step = 1'b1;
                        end
                    end else if (load_en && !tio_empty[ch_q]) begin
                        emit          = 1'b1;
                        emit_data     = cur_data;
                        tio_pop[ch_q] = 1'b1;
                        beat_step     = 1'b1;
                        if (cur_last && !tio_last_beat) begin
                            err_set[ch_q] = 1'b1;
                            pad_d         = 1'b1;
                        end else if (!cur_last && tio_last_beat) begin
                            err_set[ch_q] = 1'b1;
                            drain_d       = 1'b1;
                        end
                    end
`else
                    if (load_en && !tio_empty[ch_q]) begin
                        emit          = 1'b1;
                        emit_data     = cur_data;
                        tio_pop[ch_q] = 1'b1;
                        beat_step     = 1'b1;
                    end
`endif
                end
                if (beat_step) begin
                    emit_last = last_ch && tio_last_beat;
                    if (tio_last_beat) ch_done = 1'b1;
                    else               beat_d  = beat_q + 1'b1;
                end
`ifdef HDR_ASSEMBLER_LENCHK_EN
                if (drain_d && !drain_q) ch_done = 1'b0;
                if (ch_done) pad_d = 1'b0;
`endif
                if (ch_done) begin
                    beat_d = '0;
                    if (last_ch) state_d = ST_IDLE;
                    else         ch_d    = ch_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
            beat_q  <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            beat_q  <= beat_d;
            mask_q  <= mask_d;
        end
    end

`ifdef HDR_ASSEMBLER_LENCHK_EN
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            pad_q   <= 1'b0;
            drain_q <= 1'b0;
            err_q   <= '0;
        end else begin
            pad_q   <= pad_d;
            drain_q <= drain_d;
            err_q   <= err_q | err_set;
        end
    end
`endif

    // Output register: reloads only when empty or being accepted, so data holds under backpressure.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            m_hdr_tvalid <= 1'b0;
            m_hdr_tdata  <= '0;
            m_hdr_tlast  <= 1'b0;
        end else if (load_en) begin
            m_hdr_tvalid <= emit;
            m_hdr_tlast  <= emit && emit_last;
            if (emit) m_hdr_tdata <= emit_data;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            event_count_o <= '0;
        end else if (m_hdr_tvalid && m_hdr_tready && m_hdr_tlast) begin
            event_count_o <= event_count_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_hdr_assembler.sv
// Scoreboard bench for hdr_assembler: expected records are queued as stimulus
// is driven and compared beat by beat as the assembled stream is accepted.
module tb_hdr_assembler;

    localparam int NT = 4;
    localparam int DW = 64;
    localparam int REC_BEATS = 8 + NT * 4;
`ifdef HDR_ASSEMBLER_LENCHK_EN
    localparam bit LENCHK = 1'b1;
`else
    localparam bit LENCHK = 1'b0;
`endif

    logic             aclk = 1'b0;
    logic             areset = 1'b1;
    logic [NT-1:0]    tio_mask_i = '0;
    logic [DW-1:0]    s_thdr_tdata = '0;
    logic             s_thdr_tvalid = 1'b0;
    logic             s_thdr_tready;
    logic             s_thdr_tlast = 1'b0;
    logic [NT*DW-1:0] s_hdr_tdata = '0;
    logic [NT-1:0]    s_hdr_tvalid = '0;
    logic [NT-1:0]    s_hdr_tready;
    logic [NT-1:0]    s_hdr_tlast = '0;
    logic [DW-1:0]    m_hdr_tdata;
    logic             m_hdr_tvalid;
    logic             m_hdr_tready = 1'b0;
    logic             m_hdr_tlast;
    logic [15:0]      event_count_o;
    logic [NT-1:0]    err_o;

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          rdy_mode = 0;
    int          exp_events = 0;
    int          last_span = 0;
    logic [DW:0] exp_q [$];

    hdr_assembler #(
        .NUM_TIO(NT), .DATA_WIDTH(DW), .THDR_BEATS(8), .TIO_BEATS(4),
        .FIFO_DEPTH(16), .FAKE_MAGIC(16'hFA6E)
    ) dut (
        .aclk(aclk), .areset(areset), .tio_mask_i(tio_mask_i),
        .s_thdr_tdata(s_thdr_tdata), .s_thdr_tvalid(s_thdr_tvalid),
        .s_thdr_tready(s_thdr_tready), .s_thdr_tlast(s_thdr_tlast),
        .s_hdr_tdata(s_hdr_tdata), .s_hdr_tvalid(s_hdr_tvalid),
        .s_hdr_tready(s_hdr_tready), .s_hdr_tlast(s_hdr_tlast),
        .m_hdr_tdata(m_hdr_tdata), .m_hdr_tvalid(m_hdr_tvalid),
        .m_hdr_tready(m_hdr_tready), .m_hdr_tlast(m_hdr_tlast),
        .event_count_o(event_count_o), .err_o(err_o)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc++;

    always @(posedge aclk) begin
        #1;
        case (rdy_mode)
            0:       m_hdr_tready = 1'b0;
            1:       m_hdr_tready = 1'b1;
            default: m_hdr_tready = 1'($urandom_range(0, 1));
        endcase
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [DW:0] obs, input logic [DW:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] thdr_beat(input int r, input int j);
        return {16'hA5A5, 8'(r), 8'h00, 24'h0, 8'(j)};
    endfunction
    function automatic logic [DW-1:0] tio_beat(input int r, input int c, input int j);
        return {16'hC0DE, 8'(r), 8'(c), 24'h0, 8'(j)};
    endfunction
    function automatic logic [DW-1:0] fake_beat(input int c, input int j);
        return {16'hFA6E, 8'(c), 8'(j), 32'h0};
    endfunction
    function automatic logic [DW-1:0] garbage(input int j);
        return {32'hDEADBEEF, 24'h0, 8'(j)};
    endfunction

    // Output monitor: scoreboard compare, record length, and hold-under-stall.
    logic        prev_stall = 1'b0;
    logic [DW:0] prev_beat = '0;
    int          rec_beats = 0;
    int          first_cyc = 0;
    always @(negedge aclk) begin
        if (areset) begin
            prev_stall = 1'b0;
            rec_beats  = 0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", (DW+1)'(m_hdr_tvalid), (DW+1)'(1));
                check("hold_beat", {m_hdr_tlast, m_hdr_tdata}, prev_beat);
            end
            if (m_hdr_tvalid && m_hdr_tready) begin
                n_tests++;
                assert (exp_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_beat: observed %h with empty scoreboard", m_hdr_tdata);
                end
                if (exp_q.size() != 0) check("beat", {m_hdr_tlast, m_hdr_tdata}, exp_q.pop_front());
                if (rec_beats == 0) first_cyc = cyc;
                rec_beats++;
                if (m_hdr_tlast) begin
                    check("record_len", (DW+1)'(rec_beats), (DW+1)'(REC_BEATS));
                    last_span = cyc - first_cyc;
                    rec_beats = 0;
                end
            end
            prev_stall = m_hdr_tvalid && !m_hdr_tready;
            prev_beat  = {m_hdr_tlast, m_hdr_tdata};
        end
    end

    // Stimulus tasks start and end at posedge+1.
    task automatic send_thdr(input logic [DW-1:0] d, input logic last);
        int t = 0;
        s_thdr_tdata = d; s_thdr_tlast = last; s_thdr_tvalid = 1'b1;
        @(negedge aclk);
        while (!s_thdr_tready && t < 1000) begin @(negedge aclk); t++; end
        check("thdr_accept", (DW+1)'(s_thdr_tready), (DW+1)'(1));
        @(posedge aclk); #1;
        s_thdr_tvalid = 1'b0;
    endtask

    task automatic send_tio(input int c, input logic [DW-1:0] d, input logic last);
        int t = 0;
        s_hdr_tdata[c*DW +: DW] = d; s_hdr_tlast[c] = last; s_hdr_tvalid[c] = 1'b1;
        @(negedge aclk);
        while (!s_hdr_tready[c] && t < 1000) begin @(negedge aclk); t++; end
        check("tio_accept", (DW+1)'(s_hdr_tready[c]), (DW+1)'(1));
        @(posedge aclk); #1;
        s_hdr_tvalid[c] = 1'b0;
    endtask

    task automatic send_record(input int r, input logic [NT-1:0] emask, input bit delay3, input bit short1);
        logic [DW-1:0] d;
        logic          lst;
        for (int j = 0; j < 8; j++) exp_q.push_back({1'b0, thdr_beat(r, j)});
        for (int c = 0; c < NT; c++) begin
            for (int j = 0; j < 4; j++) begin
                if (emask[c])                                  d = fake_beat(c, j);
                else if (short1 && c == 1 && j > 1 && LENCHK)  d = '0;
                else                                           d = tio_beat(r, c, j);
                exp_q.push_back({(c == NT-1 && j == 3), d});
            end
        end
        exp_events++;
        for (int j = 0; j < 8; j++) send_thdr(thdr_beat(r, j), j == 7);
        for (int c = 0; c < NT; c++) begin
            if (c == NT-1 && delay3) begin repeat (50) @(posedge aclk); #1; end
            for (int j = 0; j < 4; j++) begin
                if (short1 && c == 1 && j > 1 && LENCHK) continue;
                lst = (short1 && c == 1) ? (j == 1) : (j == 3);
                send_tio(c, emask[c] ? garbage(j) : tio_beat(r, c, j), lst);
            end
        end
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (exp_q.size() != 0 && t < 3000) begin @(posedge aclk); t++; end
        check({tag, "_drained"}, (DW+1)'(exp_q.size()), (DW+1)'(0));
        @(posedge aclk); #1;
        check({tag, "_event_count"}, (DW+1)'(event_count_o), (DW+1)'(exp_events));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_tvalid"}, (DW+1)'(m_hdr_tvalid), (DW+1)'(0));
        check({tag, "_tlast"}, (DW+1)'(m_hdr_tlast), (DW+1)'(0));
        check({tag, "_tdata"}, (DW+1)'(m_hdr_tdata), (DW+1)'(0));
        check({tag, "_event_count"}, (DW+1)'(event_count_o), (DW+1)'(0));
        check({tag, "_err"}, (DW+1)'(err_o), (DW+1)'(0));
        check({tag, "_thdr_tready"}, (DW+1)'(s_thdr_tready), (DW+1)'(1));
        check({tag, "_hdr_tready"}, (DW+1)'(s_hdr_tready), (DW+1)'({NT{1'b1}}));
    endtask

    initial begin
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check_reset("reset");
        @(posedge aclk); #1;
        areset = 1'b0;

        // Pre-filled record drained at full rate: 24 consecutive beats.
        rdy_mode = 0;
        send_record(1, 4'b0000, 1'b0, 1'b0);
        rdy_mode = 1;
        wait_done("prefill");
        check("prefill_span", (DW+1)'(last_span), (DW+1)'(REC_BEATS - 1));

        // Channel 2 masked with garbage on its input.
        tio_mask_i = 4'b0100;
        send_record(2, 4'b0100, 1'b0, 1'b0);
        wait_done("mask_ch2");
        tio_mask_i = 4'b0000;

        // Late channel 3, then the same with random backpressure.
        send_record(3, 4'b0000, 1'b1, 1'b0);
        wait_done("late_ch3");
        rdy_mode = 2;
        send_record(4, 4'b0000, 1'b1, 1'b0);
        wait_done("toggle_ready");
        rdy_mode = 1;

        // Mask change during THDR affects only the following record.
        rdy_mode = 0;
        send_record(5, 4'b0000, 1'b0, 1'b0);
        rdy_mode = 1;
        tio_mask_i = 4'b0001;
        wait_done("mask_flip_cur");
        send_record(6, 4'b0001, 1'b0, 1'b0);
        wait_done("mask_flip_next");
        tio_mask_i = 4'b0000;
        check("err_before_short", (DW+1)'(err_o), (DW+1)'(0));

        // Channel 1 ends early, followed by a normal record.
        send_record(7, 4'b0000, 1'b0, 1'b1);
        wait_done("short_ch1");
        check("err_short", (DW+1)'(err_o), (DW+1)'(LENCHK ? 4'b0010 : 4'b0000));
        send_record(8, 4'b0000, 1'b0, 1'b0);
        wait_done("after_short");

        // Fill the TURF FIFO under backpressure, then reset mid-record.
        rdy_mode = 0;
        repeat (2) @(posedge aclk); #1;
        for (int j = 0; j < 17; j++) send_thdr(thdr_beat(15, j), 1'b0);
        @(negedge aclk);
        check("thdr_full_tready", (DW+1)'(s_thdr_tready), (DW+1)'(0));
        @(posedge aclk); #1;
        send_tio(0, tio_beat(15, 0, 0), 1'b0);
        send_tio(0, tio_beat(15, 0, 1), 1'b0);
        areset = 1'b1;
        @(negedge aclk);
        check_reset("midreset");
        @(posedge aclk); #1;
        areset = 1'b0;
        exp_q.delete();
        exp_events = 0;
        @(negedge aclk);
        check_reset("post_reset");
        @(posedge aclk); #1;
        rdy_mode = 1;
        send_record(9, 4'b0000, 1'b0, 1'b0);
        wait_done("after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
